// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the Hack CPU
// and the video scanout reader (req/ack reads, bounded latency).
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_sel,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_VID_RD
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  vvalid_q, vvalid_d;
  logic                  cpu_cap_q, cpu_cap_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_cap_d   = cpu_sel & (state_q != S_VID_RD);
    vvalid_d    = (state_q == S_VID_RD);
    if (cpu_cap_q) cpu_rdata_d = ram_rdata;
    if (vvalid_q) vid_rdata_d = ram_rdata;
    unique case (state_q)
      S_IDLE: begin
        if (vid_req) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_VID_RD;
        else cnt_d = cnt_q - CW'(1);
      end
      S_VID_RD: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // status flags follow the next state so they come straight off flops
    busy_d = (state_d != S_IDLE);
    ack_d  = (state_d == S_VID_RD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      vvalid_q    <= 1'b0;
      cpu_cap_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      vvalid_q    <= vvalid_d;
      cpu_cap_q   <= cpu_cap_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign cpu_busy  = busy_q;
  assign vid_ack   = ack_q;
  assign vid_valid = vvalid_q;
  assign cpu_rdata = cpu_rdata_q;
  // RAM word arrives during the valid pulse; bypass it so data and valid align
  assign vid_rdata = vvalid_q ? ram_rdata : vid_rdata_q;

  assign ram_addr  = (state_q == S_VID_RD) ? vid_addr : cpu_addr;
  assign ram_we    = reset_n & cpu_we & cpu_sel & (state_q == S_IDLE);
  assign ram_wdata = cpu_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table-driven vectors plus hand sequences for reset,
// and back-to-back video reads interleaved with CPU writes.
module tb_vram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_sel;
  logic [12:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic        cpu_busy;
  logic [15:0] cpu_rdata;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic        vid_valid;
  logic [15:0] vid_rdata;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:8191];

  int passed = 0;
  int total  = 0;

  vram_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_sel   (cpu_sel),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_rdata (cpu_rdata),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_valid (vid_valid),
    .vid_rdata (vid_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM, read-before-write, one cycle latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        sel;
    logic        we;
    logic [12:0] ca;
    logic [15:0] wd;
    logic        req;
    logic [12:0] va;
    logic        busy;
    logic        ack;
    logic        val;
    logic        rwe;
    logic [12:0] ra;
    logic        ccr;
    logic [15:0] crd;
    logic        cvr;
    logic [15:0] vrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic sel, input logic we, input logic [12:0] ca,
    input logic [15:0] wd, input logic req, input logic [12:0] va,
    input logic busy, input logic ack, input logic val,
    input logic rwe, input logic [12:0] ra,
    input logic ccr, input logic [15:0] crd,
    input logic cvr, input logic [15:0] vrd);
    vec_t v;
    v.sel = sel; v.we = we; v.ca = ca; v.wd = wd;
    v.req = req; v.va = va; v.busy = busy; v.ack = ack;
    v.val = val; v.rwe = rwe; v.ra = ra;
    v.ccr = ccr; v.crd = crd; v.cvr = cvr; v.vrd = vrd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic we, input logic [12:0] ca,
                       input logic [15:0] wd, input logic req,
                       input logic [12:0] va);
    cpu_sel = sel; cpu_we = we; cpu_addr = ca;
    cpu_wdata = wd; vid_req = req; vid_addr = va;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, valids, w, last_ack, cyc;

    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[13'h0123] = 16'hBEEF;
    mem[13'h0010] = 16'h1234;
    for (int i = 0; i < 8; i++) mem[13'h0400 + 13'(i)] = 16'hC000 + 16'(i);

    // video only
    tbl.push_back(mk(0,0,0,0,1,13'h123, 0,0,0,0,13'h000, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,13'h123, 1,0,0,0,13'h000, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,13'h123, 1,0,0,0,13'h000, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,13'h123, 1,1,0,0,13'h123, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,13'h123, 0,0,1,0,13'h000, 0,0,1,16'hBEEF));
    tbl.push_back(mk(0,0,0,0,0,13'h123, 0,0,0,0,13'h000, 0,0,1,16'hBEEF));
    // CPU read racing a video request
    tbl.push_back(mk(1,0,13'h010,0,1,13'h123, 0,0,0,0,13'h010, 0,0,0,0));
    tbl.push_back(mk(1,0,13'h010,0,1,13'h123, 1,0,0,0,13'h010, 0,0,0,0));
    tbl.push_back(mk(1,0,13'h010,0,1,13'h123, 1,0,0,0,13'h010, 1,16'h1234,0,0));
    tbl.push_back(mk(1,0,13'h010,0,1,13'h123, 1,1,0,0,13'h123, 1,16'h1234,0,0));
    tbl.push_back(mk(0,0,0,0,0,13'h123, 0,0,1,0,13'h000, 1,16'h1234,1,16'hBEEF));
    // write and request in the same IDLE cycle
    tbl.push_back(mk(1,1,13'h001,16'h00FF,1,13'h001, 0,0,0,1,13'h001, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,13'h001, 1,0,0,0,13'h000, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,13'h001, 1,0,0,0,13'h000, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,13'h001, 1,1,0,0,13'h001, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,13'h001, 0,0,1,0,13'h000, 0,0,1,16'h00FF));
    // write blocked during DRAIN/VID_RD, lands in next IDLE
    tbl.push_back(mk(0,0,0,0,1,13'h123, 0,0,0,0,13'h000, 0,0,0,0));
    tbl.push_back(mk(1,1,13'h200,16'h5A5A,1,13'h123, 1,0,0,0,13'h200, 0,0,0,0));
    tbl.push_back(mk(1,1,13'h200,16'h5A5A,1,13'h123, 1,0,0,0,13'h200, 0,0,0,0));
    tbl.push_back(mk(1,1,13'h200,16'h5A5A,1,13'h123, 1,1,0,0,13'h123, 0,0,0,0));
    tbl.push_back(mk(1,1,13'h200,16'h5A5A,0,13'h123, 0,0,1,1,13'h200, 0,0,1,16'hBEEF));
    tbl.push_back(mk(1,0,13'h200,0,0,13'h123, 0,0,0,0,13'h200, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,13'h123, 0,0,0,0,13'h000, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,13'h123, 0,0,0,0,13'h000, 1,16'h5A5A,0,0));

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_busy", 0, cpu_busy, 0);
    chk("rst_ack", 0, vid_ack, 0);
    chk("rst_valid", 0, vid_valid, 0);
    chk("rst_cpu_rdata", 0, cpu_rdata, 0);
    chk("rst_vid_rdata", 0, vid_rdata, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      tick();
      drive(tbl[i].sel, tbl[i].we, tbl[i].ca, tbl[i].wd,
            tbl[i].req, tbl[i].va);
      #1;
      chk("busy", i, cpu_busy, tbl[i].busy);
      chk("ack", i, vid_ack, tbl[i].ack);
      chk("valid", i, vid_valid, tbl[i].val);
      chk("ram_we", i, ram_we, tbl[i].rwe);
      chk("ram_addr", i, ram_addr, tbl[i].ra);
      if (tbl[i].ccr) chk("cpu_rdata", i, cpu_rdata, tbl[i].crd);
      if (tbl[i].cvr) chk("vid_rdata", i, vid_rdata, tbl[i].vrd);
    end

    // async reset in the middle of VID_RD
    tick();
    drive(0, 0, 0, 0, 1, 13'h123);
    tick();
    tick();
    tick();
    #1;
    chk("pre_rst_ack", 0, vid_ack, 1);
    drive(1, 1, 13'h050, 16'h7777, 1, 13'h123);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 0, cpu_busy, 0);
    chk("arst_ack", 0, vid_ack, 0);
    chk("arst_ram_we", 0, ram_we, 0);
    chk("arst_cpu_rdata", 0, cpu_rdata, 0);
    chk("arst_vid_rdata", 0, vid_rdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("arst_valid", i, vid_valid, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("post_rst_busy", i, cpu_busy, 0);
      chk("post_rst_valid", i, vid_valid, 0);
    end
    chk("post_rst_mem", 0, mem[13'h050], 0);

    // fresh request after release
    tick();
    drive(0, 0, 0, 0, 1, 13'h123);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) vid_req = 1'b0;
      #1;
      chk("fresh_ack", i, vid_ack, (i == 3) ? 1 : 0);
      chk("fresh_valid", i, vid_valid, (i == 4) ? 1 : 0);
    end
    chk("fresh_vid_rdata", 0, vid_rdata, 16'hBEEF);

    // eight back-to-back video reads with a CPU write retried into each gap
    acks = 0; valids = 0; w = 0; last_ack = 0; cyc = 0;
    while ((acks < 8 || valids < 8 || w < 8) && cyc < 80) begin
      tick();
      vid_req  = (acks < 8);
      vid_addr = 13'h0400 + 13'(acks);
      cpu_sel  = (w < 8);
      cpu_we   = (w < 8);
      cpu_addr = 13'h0300 + 13'(w);
      cpu_wdata = 16'hA000 + 16'(w);
      #1;
      chk("b2b_ram_we", cyc, ram_we, (!cpu_busy && w < 8) ? 1 : 0);
      if (!cpu_busy && w < 8) w++;
      if (vid_ack) begin
        if (acks > 0) chk("b2b_ack_gap", acks, cyc - last_ack, 4);
        last_ack = cyc;
        acks++;
      end
      if (vid_valid) begin
        chk("b2b_vid_rdata", valids, vid_rdata, 16'hC000 + 16'(valids));
        valids++;
      end
      cyc++;
    end
    chk("b2b_acks", 0, acks, 8);
    chk("b2b_valids", 0, valids, 8);
    chk("b2b_writes", 0, w, 8);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 8; i++)
      chk("b2b_mem", i, mem[13'h0300 + 13'(i)], 16'hA000 + 16'(i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the Hack CPU and the video scanout reader. The CPU observes `cpu_busy` as its memory-busy input and stalls VRAM accesses while it is high. The video reader issues one-word read requests over a req/ack handshake. The arbiter guarantees two things: a CPU access that saw `cpu_busy` low is never pre-empted before its read data is sampled, and every video request is served within a fixed bound.

## Interface

Parameters:
- `ADDR_WIDTH`, 13: VRAM word address width (8K words, CPU 0x4000–0x5FFF).
- `DATA_WIDTH`, 16: word width.
- `DRAIN_CYCLES`, 2: cycles the CPU keeps the RAM port after `cpu_busy` rises.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_sel`  in  1  CPU address decodes to VRAM this cycle.
- `cpu_addr`  in  ADDR_WIDTH  CPU word address (low bits of CPU A register).
- `cpu_we`  in  1  CPU write strobe (CPU memory-load).
- `cpu_wdata`  in  DATA_WIDTH  CPU write data.
- `cpu_busy`  out  1  VRAM unavailable to the CPU; drives CPU memory-busy.
- `cpu_rdata`  out  DATA_WIDTH  registered CPU read data.
- `vid_req`  in  1  video read request; level, held until `vid_ack`.
- `vid_addr`  in  ADDR_WIDTH  video read address; stable while `vid_req`.
- `vid_ack`  out  1  one-cycle pulse: address consumed, requester drops `vid_req` next cycle.
- `vid_valid`  out  1  one-cycle pulse: `vid_rdata` holds the requested word.
- `vid_rdata`  out  DATA_WIDTH  video read data, held until next `vid_valid`.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_WIDTH  RAM write data (= `cpu_wdata`).
- `ram_rdata`  in  DATA_WIDTH  RAM read data, one-cycle synchronous latency.

## Operation

States:
- IDLE: CPU owns the port, `cpu_busy`=0.
  - `vid_req`=1 → DRAIN, counter loaded to DRAIN_CYCLES-1.
  - Otherwise stay in IDLE.
- DRAIN: `cpu_busy`=1. CPU still owns the port for reads; writes are blocked. The counter decrements each cycle; at 0 → VID_RD.
- VID_RD: `cpu_busy`=1, `ram_addr`=`vid_addr`, `vid_ack`=1, next state IDLE unconditionally. This guarantees the CPU at least one `cpu_busy`-low cycle between video reads.

Datapath:
- `cpu_busy` and `vid_ack` are decoded from the registered state only. They have no combinational path from inputs.
- `ram_addr` = `cpu_addr` in IDLE and DRAIN; `vid_addr` in VID_RD.
- `ram_we` = `cpu_we & cpu_sel & (state==IDLE)`. A write strobe during DRAIN or VID_RD is dropped; the CPU retries it once `cpu_busy` falls.
- `cpu_rdata` loads `ram_rdata` when the previous cycle was IDLE or DRAIN with `cpu_sel`=1. Otherwise it holds.
- `vid_rdata` loads `ram_rdata` and `vid_valid` pulses in the cycle after VID_RD.
- A `vid_req` that arrives during DRAIN or VID_RD is evaluated on the next IDLE cycle.

## Timing

- Reset (`reset_n`=0, asynchronous): state IDLE, counter 0, `cpu_busy`=0, `vid_ack`=0, `vid_valid`=0, `cpu_rdata`=0, `vid_rdata`=0, capture flags 0, `ram_we`=0.
  - Assertion mid-DRAIN or mid-VID_RD aborts the request with no `vid_valid`.
  - The first video request after release starts fresh.
- Video latency: `vid_req` first seen in IDLE at cycle r gives DRAIN at r+1..r+DRAIN_CYCLES, VID_RD (`vid_ack`) at r+DRAIN_CYCLES+1, and `vid_valid` at r+DRAIN_CYCLES+2. Worst case is 4 cycles from request to ack, including one pending VID_RD ahead of it.
- CPU guarantee: a CPU access seeing `cpu_busy`=0 at cycle t owns the port for t..t+2. `cpu_rdata` holds the addressed word from t+2 onward, satisfying a CPU that samples at t+3.
- `vid_req` and a CPU write in the same IDLE cycle: the write commits that cycle, and DRAIN follows.

## Test plan

- Async reset: pull `reset_n` low during VID_RD → all outputs 0 immediately, no `vid_valid`. After release, `cpu_busy`=0.
- Video only: `cpu_sel`=0, RAM[0x0123]=0xBEEF, `vid_req` at cycle 0 → `cpu_busy`=1 cycles 1–3, `vid_ack` cycle 3, `vid_valid` cycle 4 with `vid_rdata`=0xBEEF.
- CPU read racing video: RAM[0x0010]=0x1234, cycle 0 `cpu_sel`=1 addr 0x0010 with `vid_req`=1 → `ram_addr`=0x0010 cycles 0–2, `cpu_rdata`=0x1234 at cycle 3, `vid_ack` cycle 3.
- Blocked write: `cpu_we`=1 addr 0x0200 data 0x5A5A held from cycle 1 (DRAIN) → `ram_we`=0 through VID_RD. Write lands in the next IDLE cycle; a later read returns 0x5A5A.
- Same-cycle write and request: cycle 0 IDLE, `cpu_we`=1 addr 0x0001 data 0x00FF, `vid_req`=1 addr 0x0001 → `ram_we`=1 cycle 0, `vid_rdata`=0x00FF at cycle 4.
- Back-to-back video with CPU writes in each gap: 8 requests → exactly one IDLE cycle between consecutive VID_RD states. Every CPU write is committed and no write is lost.
